// File: rtl/object_tracker.sv
// Grid object tracker: per-object position/direction registers updated by move/turn
// requests, blocked at the board edge, by another object, or by a wall in board RAM.
module object_tracker #(
    parameter int N_OBJ    = 4,
    parameter int COL_BITS = 4,
    parameter int ROW_BITS = 4,
    localparam int PW = ROW_BITS + COL_BITS,
    localparam int OW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [OW-1:0] req_obj,
    input  logic [1:0]    req_dir,
    input  logic          req_turn,
    output logic          ram_rd,
    output logic [PW-1:0] ram_addr,
    input  logic [7:0]    ram_rdata,
    output logic          done_valid,
    output logic [OW-1:0] done_obj,
    output logic [PW-1:0] done_pos,
    output logic [1:0]    done_dir,
    output logic          done_blocked,
    input  logic [OW-1:0] rd_obj,
    output logic [PW-1:0] rd_pos,
    output logic [1:0]    rd_dir
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC   = 3'd1;
    localparam logic [2:0] RDWAIT = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]                  state;
    logic [N_OBJ-1:0][PW-1:0]    pos_q;
    logic [N_OBJ-1:0][1:0]       dir_q;
    logic [OW-1:0]               obj_q;
    logic [1:0]                  dir_l;
    logic                        turn_q;
    logic [PW-1:0]               tgt_q;
    logic [PW-1:0]               addr_q;

    logic                        obj_ok;
    logic [PW-1:0]               cur_pos;
    logic [ROW_BITS-1:0]         row, t_row;
    logic [COL_BITS-1:0]         col, t_col;
    logic [PW-1:0]               target;
    logic                        edge_blk, occ_blk;
    logic                        ram_unused;

    assign ram_unused = ^ram_rdata[6:0];
    assign req_ready  = (state == IDLE);
    assign done_valid = (state == DONE);

    // Target and blocking are evaluated from the latched request against current registers.
    always_comb begin
        obj_ok  = 1'b0;
        cur_pos = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (obj_q == OW'(i)) begin
                obj_ok  = 1'b1;
                cur_pos = pos_q[i];
            end
        end
        row      = cur_pos[PW-1:COL_BITS];
        col      = cur_pos[COL_BITS-1:0];
        t_row    = row;
        t_col    = col;
        edge_blk = 1'b0;
        case (dir_l)
            2'b00: begin edge_blk = (row == '0); t_row = row - ROW_BITS'(1); end
            2'b01: begin edge_blk = (row == '1); t_row = row + ROW_BITS'(1); end
            2'b10: begin edge_blk = (col == '0); t_col = col - COL_BITS'(1); end
            default: begin edge_blk = (col == '1); t_col = col + COL_BITS'(1); end
        endcase
        target  = {t_row, t_col};
        occ_blk = 1'b0;
        for (int unsigned j = 0; j < N_OBJ; j++) begin
            if (obj_q != OW'(j) && pos_q[j] == target) occ_blk = 1'b1;
        end
    end

    assign ram_rd   = (state == CALC) && obj_ok && !turn_q && !edge_blk && !occ_blk;
    assign ram_addr = ram_rd ? target : addr_q;

    always_comb begin
        rd_pos = '0;
        rd_dir = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (rd_obj == OW'(i)) begin
                rd_pos = pos_q[i];
                rd_dir = dir_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                pos_q[i] <= PW'(i);
                dir_q[i] <= 2'b01;
            end
            obj_q        <= '0;
            dir_l        <= '0;
            turn_q       <= 1'b0;
            tgt_q        <= '0;
            addr_q       <= '0;
            done_obj     <= '0;
            done_pos     <= '0;
            done_dir     <= '0;
            done_blocked <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        obj_q  <= req_obj;
                        dir_l  <= req_dir;
                        turn_q <= req_turn;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < N_OBJ; i++) begin
                        if (obj_q == OW'(i)) dir_q[i] <= dir_l;
                    end
                    if (ram_rd) begin
                        addr_q <= target;
                        tgt_q  <= target;
                        state  <= RDWAIT;
                    end else begin
                        // Without a RAM read only a valid turn-only request is unblocked.
                        done_obj     <= obj_q;
                        done_dir     <= dir_l;
                        done_pos     <= cur_pos;
                        done_blocked <= !(obj_ok && turn_q);
                        state        <= DONE;
                    end
                end
                RDWAIT: state <= CHECK;
                CHECK: begin
                    done_obj     <= obj_q;
                    done_dir     <= dir_l;
                    done_blocked <= ram_rdata[7];
                    if (ram_rdata[7]) begin
                        done_pos <= cur_pos;
                    end else begin
                        done_pos <= tgt_q;
                        for (int unsigned i = 0; i < N_OBJ; i++) begin
                            if (obj_q == OW'(i)) pos_q[i] <= tgt_q;
                        end
                    end
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_object_tracker.sv
// Randomized self-checking bench for object_tracker against a row/column reference model.
module tb_object_tracker;

    localparam int N_OBJ    = 4;
    localparam int COL_BITS = 4;
    localparam int ROW_BITS = 4;
    localparam int PW       = ROW_BITS + COL_BITS;
    localparam int OW       = 2;
    localparam int ROWS     = 1 << ROW_BITS;
    localparam int COLS     = 1 << COL_BITS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [OW-1:0] req_obj = '0;
    logic [1:0]    req_dir = '0;
    logic          req_turn = 1'b0;
    logic          ram_rd;
    logic [PW-1:0] ram_addr;
    logic [7:0]    ram_rdata = '0;
    logic          done_valid;
    logic [OW-1:0] done_obj;
    logic [PW-1:0] done_pos;
    logic [1:0]    done_dir;
    logic          done_blocked;
    logic [OW-1:0] rd_obj = '0;
    logic [PW-1:0] rd_pos;
    logic [1:0]    rd_dir;

    object_tracker #(.N_OBJ(N_OBJ), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_obj(req_obj), .req_dir(req_dir), .req_turn(req_turn),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .done_valid(done_valid), .done_obj(done_obj), .done_pos(done_pos),
        .done_dir(done_dir), .done_blocked(done_blocked),
        .rd_obj(rd_obj), .rd_pos(rd_pos), .rd_dir(rd_dir)
    );

    always #10 clk = ~clk;

    int mpos [N_OBJ];
    int mdir [N_OBJ];
    bit board [ROWS*COLS];
    int last_addr;
    bit last_valid;
    int n_checks = 0;
    int n_pass = 0;

    // Board RAM: data for a strobed address appears two cycles later, junk otherwise.
    logic          p_valid = 1'b0;
    logic [PW-1:0] p_addr = '0;
    always @(posedge clk) begin
        if (p_valid) ram_rdata <= {board[p_addr], 7'($urandom)};
        else         ram_rdata <= 8'($urandom);
        p_valid <= ram_rd;
        p_addr  <= ram_addr;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_OBJ; i++) begin
            mpos[i] = i;
            mdir[i] = 1;
        end
        last_valid = 1'b0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < N_OBJ; i++) begin
            rd_obj = OW'(i);
            #1;
            check_val("rd_pos", 32'(rd_pos), mpos[i]);
            check_val("rd_dir", 32'(rd_dir), mdir[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 1);
        check_val("rst_done_valid", 32'(done_valid), 0);
        check_val("rst_ram_rd", 32'(ram_rd), 0);
        check_val("rst_done_obj", 32'(done_obj), 0);
        check_val("rst_done_pos", 32'(done_pos), 0);
        check_val("rst_done_dir", 32'(done_dir), 0);
        check_val("rst_done_blocked", 32'(done_blocked), 0);
        reset = 1'b1;
        model_reset();
        check_regs();
    endtask

    // Issue one request at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic do_req(input int o, input int d, input bit t, input bit hold);
        int r, c, nr, nc, tgt, lat, n, rd_cnt, rd_n, rd_a;
        bit edge_hit, occ, ram_exp, blk, seen_done;
        r  = mpos[o] / COLS;
        c  = mpos[o] % COLS;
        nr = r;
        nc = c;
        case (d)
            0: nr = r - 1;
            1: nr = r + 1;
            2: nc = c - 1;
            default: nc = c + 1;
        endcase
        edge_hit = (nr < 0) || (nr >= ROWS) || (nc < 0) || (nc >= COLS);
        tgt = nr * COLS + nc;
        occ = 1'b0;
        for (int j = 0; j < N_OBJ; j++) if (j != o && mpos[j] == tgt) occ = 1'b1;
        ram_exp = !t && !edge_hit && !occ;
        if (t) begin
            lat = 3; blk = 1'b0;
        end else if (edge_hit || occ) begin
            lat = 3; blk = 1'b1;
        end else begin
            lat = 5;
            blk = board[tgt];
            if (!blk) mpos[o] = tgt;
            last_addr  = tgt;
            last_valid = 1'b1;
        end
        mdir[o] = d;

        check_val("ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_obj   = OW'(o);
        req_dir   = 2'(d);
        req_turn  = t;
        n = 1; rd_cnt = 0; rd_n = 0; rd_a = 0; seen_done = 1'b0;
        while (!seen_done && n < 20) begin
            @(negedge clk);
            n++;
            if (hold) begin
                req_obj  = OW'($urandom);
                req_dir  = 2'($urandom);
                req_turn = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            check_val("busy_ready", 32'(req_ready), 0);
            if (ram_rd) begin
                rd_cnt++;
                rd_n = n;
                rd_a = 32'(ram_addr);
            end
            if (done_valid) seen_done = 1'b1;
        end
        req_valid = 1'b0;
        check_val("latency", n, lat);
        check_val("ram_rd_count", rd_cnt, ram_exp ? 1 : 0);
        if (ram_exp) begin
            check_val("ram_rd_cycle", rd_n, 2);
            check_val("ram_addr", rd_a, tgt);
        end
        check_val("done_obj", 32'(done_obj), o);
        check_val("done_pos", 32'(done_pos), mpos[o]);
        check_val("done_dir", 32'(done_dir), d);
        check_val("done_blocked", 32'(done_blocked), 32'(blk));
        @(negedge clk);
        check_val("done_pulse", 32'(done_valid), 0);
        check_val("done_pos_hold", 32'(done_pos), mpos[o]);
        check_val("done_blk_hold", 32'(done_blocked), 32'(blk));
        if (last_valid) check_val("ram_addr_hold", 32'(ram_addr), last_addr);
        check_regs();
    endtask

    // Reset during RDWAIT of a free move of obj0 downward.
    task automatic do_abort();
        board[16] = 1'b0;
        check_val("abort_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_obj   = '0;
        req_dir   = 2'b01;
        req_turn  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("abort_ram_rd", 32'(ram_rd), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_no_done", 32'(done_valid), 0);
        check_val("abort_ready_next", 32'(req_ready), 1);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("abort_quiet", 32'(done_valid), 0);
        end
        check_val("abort_done_pos", 32'(done_pos), 0);
        check_val("abort_done_blocked", 32'(done_blocked), 0);
        check_regs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ROWS*COLS; i++) board[i] = 1'b0;
        model_reset();

        do_reset();
        do_req(0, 1, 1'b0, 1'b0);            // free move down to 0x10
        do_reset();
        do_req(0, 0, 1'b0, 1'b0);            // top-edge blocked
        do_req(1, 2, 1'b0, 1'b0);            // occupied by obj0
        board[8'h12] = 1'b1;
        do_req(2, 1, 1'b0, 1'b0);            // wall
        do_req(2, 3, 1'b1, 1'b0);            // turn only
        for (int k = 0; k < COLS - 4; k++) do_req(3, 3, 1'b0, 1'b0);
        for (int k = 0; k < ROWS - 1; k++) do_req(3, 1, 1'b0, k % 2 == 1);
        do_req(3, 3, 1'b0, 1'b1);            // right edge at 0xFF, request held
        do_req(3, 1, 1'b0, 1'b1);            // bottom edge
        do_reset();
        do_abort();

        do_reset();
        for (int i = 0; i < ROWS*COLS; i++) board[i] = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req($urandom_range(0, N_OBJ - 1), $urandom_range(0, 3),
                   $urandom_range(0, 7) == 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
